// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a synchronous FIFO: pops one word, then sends
// start bit, FIFO_w data bits LSB first, and a stop bit. Repeats while enabled and non-empty.
module fifo_uart_tx #(
    parameter int unsigned FIFO_w       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              tx_en_i,
    input  logic              fifo_empty_i,
    input  logic [FIFO_w-1:0] fifo_data_i,
    output logic              fifo_read_en_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              tx_done_o
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(FIFO_w + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(FIFO_w - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] POP   = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] DATA  = 3'd4;
    localparam logic [2:0] STOP  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [IW-1:0]     bit_q, bit_d;
    logic [FIFO_w-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              read_en_q, read_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (tx_en_i && !fifo_empty_i) begin
                    state_d = POP;
                end
            end
            POP: state_d = LOAD;
            LOAD: begin
                shift_d = fifo_data_i;
                state_d = START;
            end
            START: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            baud_d = '0;
        end
    end

    // Outputs are computed from next-state values so they stay registered yet line up with state.
    always_comb begin
        tx_d = 1'b1;
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = shift_d[0];
        end
        read_en_d = (state_d == POP);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == STOP) && (baud_d == BAUD_LAST);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            read_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            read_en_q <= read_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx_o           = tx_q;
    assign fifo_read_en_o = read_en_q;
    assign busy_o         = busy_q;
    assign tx_done_o      = done_q;

endmodule
